// File: rtl/mmu_pkg.sv
// mmu_array shared types: FSM state enum, flush length and width-check helpers.
// Used by mmu_pe and mmu_array.
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } mmu_state_e;

    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    function automatic bit acc_width_ok(input int dw, input int aw);
        return aw >= 2 * dw;
    endfunction

endpackage

// File: rtl/mmu_pe.sv
// One output-stationary PE: registered operand pass-through plus a
// wrapping signed multiply-accumulate, gated by the array step enable.
module mmu_pe
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] w_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] w_o,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]           prod_ext;

    assign prod     = $signed(a_i) * $signed(w_i);
    // signed source, so the size cast sign-extends
    assign prod_ext = ACC_WIDTH'(prod);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_o   <= '0;
            w_o   <= '0;
            acc_o <= '0;
        end else if (clr_i) begin
            a_o   <= '0;
            w_o   <= '0;
            acc_o <= '0;
        end else if (en_i) begin
            a_o   <= a_i;
            w_o   <= w_i;
            acc_o <= acc_o + prod_ext;
        end
    end

endmodule

// File: rtl/mmu_array.sv
// ROWS x COLS output-stationary systolic MMU with internal skew and row drain.
// Define MMU_RELU_EN to clamp negative output elements to zero.
module mmu_array
    import mmu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int KLEN_W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [KLEN_W-1:0]          k_len_i,
    output logic                       busy_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] data_i,
    input  logic [COLS*DATA_WIDTH-1:0] weight_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [COLS*ACC_WIDTH-1:0]  out_row_o,
    output logic [$clog2(ROWS)-1:0]    out_idx_o,
    output logic                       out_last_o,
    output logic                       done_o
);

    localparam int F     = flush_len(ROWS, COLS);
    localparam int IDX_W = $clog2(ROWS);
    localparam int FL_W  = $clog2(F + 1);
    localparam int DW    = DATA_WIDTH;

    if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_bad_width
        $error("mmu_array: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end

    mmu_state_e         state_q;
    logic [KLEN_W-1:0]  k_q;
    logic [KLEN_W-1:0]  cnt_q;
    logic [FL_W-1:0]    fl_q;
    logic [IDX_W-1:0]   row_q;
    logic               done_q;
    logic               step;
    logic               clr;

    assign clr  = (state_q == ST_IDLE) && start_i;
    assign step = ((state_q == ST_FEED) && in_valid_i)
                || (state_q == ST_FLUSH);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        k_q     <= k_len_i;
                        cnt_q   <= '0;
                        fl_q    <= '0;
                        row_q   <= '0;
                        state_q <= (k_len_i == '0) ? ST_DRAIN : ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (in_valid_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == k_q - 1'b1)
                            state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    fl_q <= fl_q + 1'b1;
                    if (fl_q == FL_W'(F - 1))
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (row_q == IDX_W'(ROWS - 1)) begin
                            row_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = state_q != ST_IDLE;
    assign in_ready_o  = state_q == ST_FEED;
    assign out_valid_o = state_q == ST_DRAIN;
    assign out_idx_o   = row_q;
    assign out_last_o  = (state_q == ST_DRAIN)
                       && (row_q == IDX_W'(ROWS - 1));
    assign done_o      = done_q;

    logic [DW-1:0]        a_bus [ROWS][COLS+1];
    logic [DW-1:0]        w_bus [ROWS+1][COLS];
    logic [ACC_WIDTH-1:0] acc   [ROWS][COLS];

    // row r data is delayed r steps; zeros are injected outside FEED
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [DW-1:0] a_in;
        assign a_in = (state_q == ST_FEED) ? data_i[r*DW +: DW] : '0;
        if (r == 0) begin : g_direct
            assign a_bus[r][0] = a_in;
        end else begin : g_line
            logic [DW-1:0] sk [r];
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < r; i++) sk[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < r; i++) sk[i] <= '0;
                end else if (step) begin
                    sk[0] <= a_in;
                    for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
                end
            end
            assign a_bus[r][0] = sk[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wskew
        logic [DW-1:0] w_in;
        assign w_in = (state_q == ST_FEED) ? weight_i[c*DW +: DW] : '0;
        if (c == 0) begin : g_direct
            assign w_bus[0][c] = w_in;
        end else begin : g_line
            logic [DW-1:0] sk [c];
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < c; i++) sk[i] <= '0;
                end else if (clr) begin
                    for (int i = 0; i < c; i++) sk[i] <= '0;
                end else if (step) begin
                    sk[0] <= w_in;
                    for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
                end
            end
            assign w_bus[0][c] = sk[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            mmu_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (step),
                .clr_i (clr),
                .a_i   (a_bus[r][c]),
                .w_i   (w_bus[r][c]),
                .a_o   (a_bus[r][c+1]),
                .w_o   (w_bus[r+1][c]),
                .acc_o (acc[r][c])
            );
        end
    end

    always_comb begin
        logic [ACC_WIDTH-1:0] val;
        val       = '0;
        out_row_o = '0;
        if (state_q == ST_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                val = acc[row_q][c];
`ifdef MMU_RELU_EN
                if (val[ACC_WIDTH-1]) val = '0;
`else
`endif
                out_row_o[c*ACC_WIDTH +: ACC_WIDTH] = val;
            end
        end
    end

endmodule

// File: tb/tb_mmu_array.sv
// Directed bench for mmu_array (4x4, 16-bit data, 32-bit acc).
// Expected tiles come from a plain sum-of-products model.
module tb_mmu_array;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KW = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [KW-1:0]     k_len_i = '0;
    logic              busy_o;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [R*DW-1:0]   data_i = '0;
    logic [C*DW-1:0]   weight_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [C*AW-1:0]   out_row_o;
    logic [1:0]        out_idx_o;
    logic              out_last_o;
    logic              done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int s_cyc = 0;

    int          da [8][R];
    int          wa [8][C];
    logic [31:0] got [R][C];
    logic [31:0] exp_t [R][C];

    mmu_array #(
        .ROWS       (R),
        .COLS       (C),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .KLEN_W     (KW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .weight_i    (weight_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_row_o   (out_row_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic model(input int k);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int s;
                s = 0;
                for (int b = 0; b < k; b++) s += da[b][r] * wa[b][c];
`ifdef MMU_RELU_EN
                if (s < 0) s = 0;
`else
`endif
                exp_t[r][c] = s;
            end
        end
    endtask

    task automatic start_tile(input int k);
        @(negedge clk_i);
        start_i = 1'b1;
        k_len_i = KW'(k);
        s_cyc   = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_cycle1", busy_o, 1'b1);
        check("in_ready_cycle1", in_ready_o, k != 0);
    endtask

    task automatic feed(input int k, input bit gaps);
        for (int b = 0; b < k; b++) begin
            in_valid_i = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
            in_valid_i = 1'b1;
            for (int r = 0; r < R; r++) data_i[r*DW +: DW] = 16'(da[b][r]);
            for (int c = 0; c < C; c++) weight_i[c*DW +: DW] = 16'(wa[b][c]);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        data_i     = '0;
        weight_i   = '0;
    endtask

    task automatic drain(input int srow, input int sn,
                         input int efv, input int edone);
        int row = 0;
        int waited = 0;
        int held = 0;
        int fv = -1;
        logic [127:0] snap = '0;
        out_ready_i = 1'b0;
        while (row < R && waited < 200) begin
            if (out_valid_o) begin
                if (fv < 0) fv = cyc - s_cyc;
                if (int'(out_idx_o) == srow && held < sn) begin
                    if (held > 0) begin
                        check("stall_row_hold", out_row_o, snap);
                        check("stall_idx_hold", out_idx_o, srow);
                    end
                    snap = out_row_o;
                    held++;
                    out_ready_i = 1'b0;
                end else begin
                    check("row_idx", out_idx_o, row);
                    check("row_last", out_last_o, row == R - 1);
                    for (int c = 0; c < C; c++)
                        got[row][c] = out_row_o[c*AW +: AW];
                    out_ready_i = 1'b1;
                    row++;
                end
            end else begin
                out_ready_i = 1'b0;
            end
            @(negedge clk_i);
            waited++;
        end
        check("drain_rows", row, R);
        if (efv >= 0) begin
            check("first_valid_cycle", fv, efv);
            check("done_cycle", cyc - s_cyc, edone);
        end
        out_ready_i = 1'b0;
        check("done_pulse", done_o, 1'b1);
        check("busy_after", busy_o, 1'b0);
        check("valid_after", out_valid_o, 1'b0);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 1'b0);
    endtask

    task automatic compare_tile(input string name);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                check($sformatf("%s_r%0d_c%0d", name, r, c),
                      got[r][c], exp_t[r][c]);
    endtask

    task automatic run_tile(input string name, input int k, input bit gaps,
                            input int srow, input int sn,
                            input int efv, input int edone);
        model(k);
        start_tile(k);
        feed(k, gaps);
        drain(srow, sn, efv, edone);
        compare_tile(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_out_last", out_last_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_out_row", out_row_o, '0);
        check("rst_out_idx", out_idx_o, '0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // K=1: row r holds r+1 everywhere
        da[0] = '{1, 2, 3, 4};
        wa[0] = '{1, 1, 1, 1};
        run_tile("k1", 1, 1'b0, -1, 0, 8, 12);

        // K=4: identity data against W rows 1..16
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < R; r++) da[b][r] = (r == b) ? 1 : 0;
            for (int c = 0; c < C; c++) wa[b][c] = 4 * b + c + 1;
        end
        run_tile("ident", 4, 1'b0, -1, 0, 11, 15);
        run_tile("ident_gaps_stall", 4, 1'b1, 1, 3, -1, -1);

        // mixed signs
        da[0] = '{3, -2, 7, -5};
        wa[0] = '{-4, 6, 1, -3};
        da[1] = '{-1, 8, -6, 2};
        wa[1] = '{5, -7, 2, 9};
        da[2] = '{4, 4, -3, -8};
        wa[2] = '{2, -1, -9, 6};
        run_tile("signed", 3, 1'b0, -1, 0, 10, 14);

        // wrap: 2 * (-32768)^2 = 2^31 wraps to -2^31
        for (int b = 0; b < 2; b++) begin
            da[b] = '{-32768, -32768, -32768, -32768};
            wa[b] = '{-32768, -32768, -32768, -32768};
        end
        run_tile("wrap", 2, 1'b0, -1, 0, 9, 13);

        run_tile("k0", 0, 1'b0, -1, 0, 1, 5);

        // abort in FEED, then a clean tile
        da[0] = '{9, 9, 9, 9};
        wa[0] = '{9, 9, 9, 9};
        da[1] = '{9, 9, 9, 9};
        wa[1] = '{9, 9, 9, 9};
        start_tile(4);
        feed(2, 1'b0);
        rst_i = 1'b0;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_in_ready", in_ready_o, 1'b0);
        check("abort_out_valid", out_valid_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_out_row", out_row_o, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        da[0] = '{2, 2, 2, 2};
        wa[0] = '{3, 3, 3, 3};
        run_tile("after_abort", 1, 1'b0, -1, 0, 8, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_array.md
# mmu_array

Parametrised ROWS×COLS output-stationary systolic matrix-multiply unit; successor to the fixed 4×4 MMU array. Accepts one K-step operand beat per handshake (a ROWS-wide data column and a COLS-wide weight row), generates input skew internally, sequences feed/flush/drain with its own FSM, and streams the accumulated ROWS×COLS tile out row by row under valid/ready. Sits between the operand buffers and the BN/writeback path in the accelerator datapath.

## Interface
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥2)
- DATA_WIDTH, 16, signed operand width
- ACC_WIDTH, 32, signed accumulator width; must be ≥ 2*DATA_WIDTH
- KLEN_W, 16, width of the K-length field
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start a tile; sampled only in IDLE
- k_len_i  in  KLEN_W  number of operand beats K, latched on accepted start
- busy_o  out  1  high whenever state ≠ IDLE
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat accepted when in_valid_i && in_ready_o
- data_i  in  ROWS*DATA_WIDTH  data element for row r at [r*DATA_WIDTH +: DATA_WIDTH]
- weight_i  in  COLS*DATA_WIDTH  weight element for column c at [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid_o  out  1  result row valid
- out_ready_i  in  1  result row consumed when out_valid_o && out_ready_i
- out_row_o  out  COLS*ACC_WIDTH  accumulators of row out_idx_o, column c at [c*ACC_WIDTH +: ACC_WIDTH]
- out_idx_o  out  $clog2(ROWS)  row index of out_row_o
- out_last_o  out  1  high with the final row (idx ROWS-1)
- done_o  out  1  one-cycle pulse after the last row handshake

## Operation
- FSM: IDLE, FEED, FLUSH, DRAIN (enum in package).
- IDLE: start_i=1 → clear all accumulators, skew registers, counters; latch K. K>0 → FEED; K=0 → DRAIN (all-zero tile).
- FEED: in_ready_o=1. Each accepted beat asserts array step enable: skew lines shift, PEs pass operands right/down and accumulate. No beat → array frozen (no shift, no accumulate). After K-th accepted beat → FLUSH.
- FLUSH: in_ready_o=0; array stepped with zero operands for F = ROWS+COLS-2 cycles unconditionally; then DRAIN.
- Skew: row r data delayed r enabled steps, column c weight delayed c enabled steps; PE(r,c) at step t uses a[r][t-r-c], w[c][t-r-c]. After K+F steps, acc(r,c) = Σk a[r][k]*w[c][k].
- DRAIN: out_valid_o=1, rows in order 0..ROWS-1; out_idx_o advances only on handshake; out_row_o/out_idx_o/out_last_o stable while out_valid_o && !out_ready_i. Handshake on last row → IDLE, done_o=1 next cycle.
- Arithmetic: full signed DATA_WIDTH×DATA_WIDTH product, sign-extended to ACC_WIDTH, accumulation wraps modulo 2^ACC_WIDTH.
- start_i outside IDLE ignored. in_valid_i outside FEED ignored.

## Timing
- Reset (async assert, sync-release expected upstream): state IDLE; busy_o, in_ready_o, out_valid_o, out_last_o, done_o = 0; out_row_o, out_idx_o, accumulators, skew registers, counters = 0.
- Reset mid-operation: tile aborted, no done_o, no partial output.
- Start accepted cycle 0 → busy_o and in_ready_o high from cycle 1.
- Throughput: 1 beat/cycle in FEED, 1 row/cycle in DRAIN with out_ready_i held high.
- Last input beat at cycle T → FLUSH cycles T+1..T+F → out_valid_o first high cycle T+F+1.
- Full tile, no stalls: 1 + K + F + ROWS cycles start-to-done_o-deassert-minus-one; done_o high on cycle after final handshake, then busy_o=0 same cycle.

## Configuration
- MMU_RELU_EN defined: out_row_o elements clamped to 0 when accumulator is negative (accumulators themselves unchanged).
- Undefined: raw signed accumulators output.

## Structure
- mmu_pkg: state enum type, flush-length function ROWS+COLS-2, width checks helper.
- Sub-module mmu_pe: one PE — registered data/weight pass-through, accumulator, step enable, synchronous clear; instantiated ROWS×COLS in generate loops. Skew lines inline in top.

## Test plan
- 4×4, K=1, data=[1,2,3,4], weight=[1,1,1,1] → row r all elements r+1; out_last_o on idx 3; done_o one pulse.
- 4×4, K=4, A=identity, W=[[1..4],[5..8],[9..12],[13..16]] beats → tile equals Wᵀ-ordered product, checked against golden model; random in_valid gaps give identical result.
- Backpressure: out_ready_i low 3 cycles on row 1 → out_row_o/out_idx_o=1 held stable, no row skipped or repeated.
- Wrap: DATA_WIDTH=16, ACC_WIDTH=32, K=2, all operands −32768 → every element −2^31 (2^31 wrapped); with MMU_RELU_EN → 0.
- K=0 start → no in_ready_o, 4 zero rows, done_o.
- rst_i low during FEED → all outputs 0 immediately; next start with K=1, data=[2,2,2,2], weight=[3,3,3,3] → all 6, no residue.
